// File: rtl/inst_axi_bridge.sv
// Fetch-side SRAM-like interface to AXI read channel bridge.
// One AR in flight at a time; up to MAX_OUTST reads awaiting R, returned in issue order.
module inst_axi_bridge #(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] ARID_VAL  = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic {IDLE, AR_BUSY} state_t;

   localparam logic [1:0] MAX_CNT = MAX_OUTST[1:0];

   state_t     state, state_nxt;
   logic [1:0] outst_cnt;
   logic       r_hs;

   // Writes are forwarded as plain reads, and R ordering is implicit, so these fields carry nothing.
   logic unused_in;
   assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

   assign arid    = ARID_VAL;
   assign arlen   = 8'd0;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign arvalid = (state == AR_BUSY);
   assign rready  = (outst_cnt != 2'd0);
   assign r_hs    = rvalid & rready;

   // Gated by reset so a held request is not acknowledged while the block is in reset.
   assign inst_sram_addr_ok = reset && (state == IDLE) && inst_sram_req && (outst_cnt < MAX_CNT);
   assign inst_sram_data_ok = r_hs;
   assign inst_sram_rdata   = rdata;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (inst_sram_addr_ok) state_nxt = AR_BUSY;
         AR_BUSY: if (arready)           state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         outst_cnt <= 2'd0;
         araddr    <= 32'd0;
         arsize    <= 3'd0;
      end else begin
         state <= state_nxt;
         if (inst_sram_addr_ok) begin
            araddr <= inst_sram_addr;
            arsize <= {1'b0, inst_sram_size};
         end
         // rready is low at zero, so a stray R beat can never underflow the count.
         if (inst_sram_addr_ok && !r_hs)
            outst_cnt <= outst_cnt + 2'd1;
         else if (r_hs && !inst_sram_addr_ok)
            outst_cnt <= outst_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: single fetch, AR backpressure, outstanding limit,
// simultaneous accept/return, mid-operation reset and write-flag handling.
module tb_inst_axi_bridge;

   logic        clk;
   logic        reset;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok, data_ok;
   logic [31:0] sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   int n_chk  = 0;
   int n_fail = 0;

   inst_axi_bridge #(.MAX_OUTST(2), .ARID_VAL(4'h3)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
      .inst_sram_addr(addr), .inst_sram_wstrb(wstrb), .inst_sram_wdata(wdata),
      .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0;
      wstrb = '0; wdata = '0; arready = 1'b0;
      rid = 4'h5; rdata = '0; rresp = 2'b10; rlast = 1'b1; rvalid = 1'b0;

      // reset state, with req and rvalid pushed against it
      #3; req = 1'b1; rvalid = 1'b1; #1;
      chk("rst_addr_ok", addr_ok, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready",  rready,  0);
      chk("rst_data_ok", data_ok, 0);
      chk("rst_araddr",  araddr,  0);
      chk("rst_arsize",  arsize,  0);
      req = 1'b0; rvalid = 1'b0;
      tick(); tick(); reset = 1'b1;

      // single fetch
      tick(); req = 1'b1; addr = 32'h1C00_0000; #2;
      chk("t1_addr_ok", addr_ok, 1);
      tick(); req = 1'b0; arready = 1'b1; #2;
      chk("t1_arvalid", arvalid, 1);
      chk("t1_araddr",  araddr,  32'h1C00_0000);
      chk("t1_arsize",  arsize,  3'b010);
      chk("t1_busy_aok", addr_ok, 0);
      chk("t1_const", {arid, arlen, arburst, arlock, arcache, arprot}, {4'h3, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
      tick(); arready = 1'b0; #2;
      chk("t1_idle_arvalid", arvalid, 0);
      tick(); rvalid = 1'b1; rdata = 32'h0280_0000; #2;
      chk("t1_data_ok", data_ok, 1);
      chk("t1_rdata",   sram_rdata, 32'h0280_0000);
      chk("t1_rready",  rready, 1);
      tick(); rvalid = 1'b0; #2;
      chk("t1_cnt0",    dut.outst_cnt, 0);
      chk("t1_rready0", rready, 0);

      // AR backpressure
      tick(); req = 1'b1; addr = 32'h1C00_0004; #2;
      chk("t2_accept_a", addr_ok, 1);
      tick(); addr = 32'h1C00_0008;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("t2_hold_arvalid", arvalid, 1);
         chk("t2_hold_araddr",  araddr,  32'h1C00_0004);
         chk("t2_hold_aok",     addr_ok, 0);
         tick();
      end
      arready = 1'b1; #2;
      chk("t2_rdy_aok", addr_ok, 0);
      tick(); arready = 1'b0; #2;
      chk("t2_accept_b", addr_ok, 1);
      tick(); req = 1'b0; arready = 1'b1; #2;
      chk("t2_araddr_b", araddr, 32'h1C00_0008);
      chk("t2_cnt2",     dut.outst_cnt, 2);

      // outstanding limit
      tick(); arready = 1'b0; req = 1'b1; addr = 32'h1C00_000C; #2;
      chk("t3_full_aok0", addr_ok, 0);
      tick(); #2;
      chk("t3_full_aok1", addr_ok, 0);
      tick(); rvalid = 1'b1; rdata = 32'h1111_1111; #2;
      chk("t3_r_data_ok", data_ok, 1);
      chk("t3_r_aok",     addr_ok, 0);
      tick(); rvalid = 1'b0; #2;
      chk("t3_after_r_aok", addr_ok, 1);
      tick(); req = 1'b0; arready = 1'b1; #2;
      chk("t3_araddr_c", araddr, 32'h1C00_000C);
      chk("t3_cnt2",     dut.outst_cnt, 2);
      tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222; #2;
      chk("t3_drain", data_ok, 1);

      // accept and return in the same cycle at count 1
      tick(); req = 1'b1; addr = 32'h1C00_0020; rdata = 32'h3333_3333; #2;
      chk("t4_aok",     addr_ok, 1);
      chk("t4_data_ok", data_ok, 1);
      chk("t4_rdata",   sram_rdata, 32'h3333_3333);
      tick(); req = 1'b0; rvalid = 1'b0; arready = 1'b1; #2;
      chk("t4_cnt1",   dut.outst_cnt, 1);
      chk("t4_araddr", araddr, 32'h1C00_0020);

      // reset while AR is pending with two reads outstanding
      tick(); arready = 1'b0; req = 1'b1; addr = 32'h1C00_0030; #2;
      chk("t5_aok", addr_ok, 1);
      tick(); req = 1'b0; #2;
      chk("t5_busy",   arvalid, 1);
      chk("t5_cnt2",   dut.outst_cnt, 2);
      #1; reset = 1'b0; #1;
      chk("t5_rst_arvalid", arvalid, 0);
      chk("t5_rst_cnt",     dut.outst_cnt, 0);
      chk("t5_rst_rready",  rready, 0);
      req = 1'b1; rvalid = 1'b1; #1;
      chk("t5_rst_aok",     addr_ok, 0);
      chk("t5_rst_data_ok", data_ok, 0);
      tick(); tick(); reset = 1'b1; req = 1'b0; #2;
      chk("t5_stray_data_ok", data_ok, 0);
      chk("t5_stray_rready",  rready, 0);
      tick(); rvalid = 1'b0;

      // write flag treated as a read
      wr = 1'b1; req = 1'b1; addr = 32'h1C00_0010; wstrb = 4'hF; wdata = 32'hDEAD_BEEF; #2;
      chk("t6_aok", addr_ok, 1);
      tick(); req = 1'b0; wr = 1'b0; arready = 1'b1; #2;
      chk("t6_arvalid", arvalid, 1);
      chk("t6_araddr",  araddr, 32'h1C00_0010);
      tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h4444_4444; #2;
      chk("t6_data_ok", data_ok, 1);
      tick(); rvalid = 1'b0; #2;
      chk("t6_cnt0", dut.outst_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
